sequenciador_varredura_4b: RTL
==============================

// Module: sequenciador_varredura_4b
// PURPOSE
//   Sequential address generator that sits directly upstream of the 4->16 active-low decoder.
//   Drives the decoder select a[3:0] through 0..15 (or 15..0) at a programmable rate.
//   Supports single-sweep or continuous sweep, pause/resume and direct load.
//   Typical use: multiplexed display/LED scan, where the one-cold decoder output enables one line at a time.
// PARAMETERS
//   DIV    4   clocks per address step; legal range 1..255 (DIV=1: one step per clock)
//   W_DIV  8   prescaler counter width; must satisfy 2**W_DIV > DIV
// PORTS
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous reset, active-low
//   start          in   1  1-cycle pulse: begin sweep (IDLE) or resume (PAUSE)
//   stop           in   1  1-cycle pulse: pause (SCAN) or abort (PAUSE)
//   modo_continuo  in   1  1 = wrap and keep sweeping; 0 = single sweep
//   dir_desc       in   1  0 = ascending, 1 = descending
//   load           in   1  load load_val into a on the next edge
//   load_val       in   4  value for load
//   a              out  4  decoder select; feeds decoder input a
//   ativo          out  1  1 while state is SCAN
//   fim            out  1  1-cycle pulse when a sweep completes
//   voltas         out  8  completed-sweep count (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, a=0, ativo=0, fim=0, voltas=0, prescaler=0. Reset takes effect immediately, including mid-sweep.
//   FSM states: IDLE, SCAN, PAUSE. All outputs are registered.
//   IDLE:
//     - start -> SCAN.
//     - a <= 0 if dir_desc=0, else 15.
//     - prescaler cleared.
//   SCAN, prescaler:
//     - Counts 0..DIV-1.
//     - tick asserts when count==DIV-1; count then returns to 0.
//   SCAN, tick with a != terminal: a <= a+1 (ascending) or a-1 (descending). Terminal = 15 ascending, 0 descending.
//   SCAN, tick with a == terminal:
//     - fim=1 for one cycle.
//     - modo_continuo=1: a wraps (15->0 or 0->15) and state stays SCAN.
//     - modo_continuo=0: a holds at terminal and state -> IDLE.
//   Every address, including the terminal one, is held for exactly DIV cycles.
//   Latency:
//     - start sampled at edge n -> ativo=1 and a=start value after edge n.
//     - First step occurs at edge n+DIV.
//   SCAN, stop: -> PAUSE. a and prescaler frozen, ativo=0.
//   PAUSE:
//     - start -> SCAN, resuming with the prescaler count preserved.
//     - stop -> IDLE; a holds its value.
//   start and stop on the same edge: stop wins, start is ignored.
//   load (any state):
//     - a <= load_val and prescaler cleared.
//     - State unchanged; load overrides any step due on that tick, and no fim is generated.
//     - load together with stop: both take effect.
//   dir_desc changed mid-sweep: the next tick uses the new direction, and the terminal is evaluated against the current dir_desc.
//   start while in SCAN: ignored.
// CONFIGURATION
//   Macro SEQ_VARREDURA_CNT_VOLTAS_EN.
//   Defined:
//     - voltas increments on every fim pulse and saturates at 255.
//     - It clears only on reset.
//   Undefined:
//     - voltas is tied to 8'd0 and no counter logic is built.
//     - Port list is identical in both builds.
// STRUCTURE
//   Shared include sequenciador_defs.vh holds:
//     - state encodings ST_IDLE=2'd0, ST_SCAN=2'd1, ST_PAUSE=2'd2;
//     - terminal constants A_MAX=4'd15, A_MIN=4'd0.
//   Sub-module divisor_tick (params DIV, W_DIV; inputs clk, rst_n, en, clr; output tick) implements the prescaler.
//     - en = (state==SCAN).
//     - clr = load or (IDLE & start).
//   The top module holds the FSM, the address register, fim and voltas.
// TESTING
//   1. DIV=4, modo_continuo=0, dir_desc=0, start
//      -> a = 0,1,..,15, each held 4 clocks
//      -> fim pulses once, 64 clocks after start
//      -> state IDLE, a=15, ativo=0.
//   2. modo_continuo=1, dir_desc=1, start
//      -> a = 15..0
//      -> at the terminal tick: fim=1 and a wraps to 15; ativo stays 1.
//   3. In SCAN at a=5: stop
//      -> a=5 held for 20 clocks, ativo=0
//      -> start -> a resumes 6,7,..; stop+start on the same edge in SCAN -> PAUSE.
//   4. In SCAN at a=3: load=1, load_val=12
//      -> next edge a=12, prescaler restarts, a=13 after 4 more clocks
//      -> load at the terminal value yields no fim.
//   5. rst_n=0 asynchronously mid-sweep (a=9)
//      -> a=0, ativo=0, fim=0 immediately without a clock edge
//      -> after release, start works normally.
//   6. With SEQ_VARREDURA_CNT_VOLTAS_EN: 3 continuous sweeps -> voltas=3; forced 300 sweeps -> voltas=255.
//      Without the macro: voltas=0 throughout.
//   All runs feed a into the 4->16 active-low decoder and check y_n == ~(16'b1 << a) each cycle.

Source files
------------

// File: rtl/sequenciador_varredura_4b_pkg.sv
// Shared types and constants for the 4-bit scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sequenciador_varredura_4b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] A_MAX = 4'd15;
  localparam logic [3:0] A_MIN = 4'd0;

  // Address at which a sweep ends for the given direction.
  function automatic logic [3:0] terminal_addr(input logic desc);
    return desc ? A_MIN : A_MAX;
  endfunction

  // Address a sweep begins at (and wraps back to) for the given direction.
  function automatic logic [3:0] first_addr(input logic desc);
    return desc ? A_MAX : A_MIN;
  endfunction

endpackage

// File: rtl/sequenciador_varredura_4b_divisor_tick.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last count as a step tick.
// Latency: tick is combinational from the count register; first tick DIV clocks after clr.
// Backpressure: none; en=0 freezes the count in place, clr forces it back to 0.
module divisor_tick #(
  parameter int DIV   = 4,
  parameter int W_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [W_DIV-1:0] LAST = W_DIV'(DIV - 1);

  logic [W_DIV-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Free-running modulo-DIV count, cleared on request, held while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W_DIV'(1);
    end
  end

endmodule

// File: rtl/sequenciador_varredura_4b.sv
// Scan address generator for a 4->16 one-cold decoder; optional sweep counter via SEQ_VARREDURA_CNT_VOLTAS_EN.
// Latency: start -> a/ativo valid after 1 clock; one address step every DIV clocks; all outputs registered.
// Backpressure: none; stop pauses the sweep (frozen a and prescaler), load overrides any pending step.
module sequenciador_varredura_4b
  import sequenciador_varredura_4b_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int W_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       modo_continuo,
  input  logic       dir_desc,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] a,
  output logic       ativo,
  output logic       fim,
  output logic [7:0] voltas
);

  state_t     state, state_nxt;
  logic [3:0] a_nxt;
  logic       fim_nxt;
  logic       tick;
  logic       pre_en;
  logic       pre_clr;

  assign pre_en  = (state == ST_SCAN);
  assign pre_clr = load | ((state == ST_IDLE) & start);
  assign ativo   = (state == ST_SCAN);

  divisor_tick #(
    .DIV   (DIV),
    .W_DIV (W_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, next address and sweep-complete pulse.
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    fim_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_SCAN;
          a_nxt     = first_addr(dir_desc);
        end
      end
      ST_SCAN: begin
        // A load on the same edge replaces the step entirely, so no fim either.
        if (tick && !load) begin
          if (a == terminal_addr(dir_desc)) begin
            fim_nxt = 1'b1;
            if (modo_continuo) a_nxt = first_addr(dir_desc);
            else               state_nxt = ST_IDLE;
          end else begin
            a_nxt = dir_desc ? a - 4'd1 : a + 4'd1;
          end
        end
        // A finished single sweep goes home even if stop arrives on that edge.
        if (stop && state_nxt == ST_SCAN) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop)       state_nxt = ST_IDLE;
        else if (start) state_nxt = ST_SCAN;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (load) a_nxt = load_val;
  end

  // Registered address and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= A_MIN;
      fim <= 1'b0;
    end else begin
      a   <= a_nxt;
      fim <= fim_nxt;
    end
  end

`ifdef SEQ_VARREDURA_CNT_VOLTAS_EN
  logic [7:0] voltas_q;

  // Saturating count of completed sweeps; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voltas_q <= 8'd0;
    end else if (fim_nxt && voltas_q != 8'hFF) begin
      voltas_q <= voltas_q + 8'd1;
    end
  end

  assign voltas = voltas_q;
`else
  assign voltas = 8'd0;
`endif

endmodule
